// File: rtl/des_result_collector.sv
// des_result_collector
//   Collects ciphertext/counter results from the DES search blocks. A masked
//   compare against a target value selects which results are kept. Kept
//   results go into a first-word-fall-through FIFO that the host pops. The
//   block also keeps checked/dropped statistics and a sticky overflow flag,
//   and holds the producer off while the FIFO is full.
//
//   Optional feature: define DES_COLLECT_TIMESTAMP_EN to add a free-running
//   32-bit cycle counter. Each entry then stores the counter value at push
//   time, and the head value appears on out_timestamp.
//
// Ports
//   clk, rst          clock (rising edge); asynchronous active-high reset
//   start, stop       pulses: IDLE->RUN (clears stats/FIFO), RUN->FLUSH
//   in_valid          one-cycle result strobe
//   in_counter        key index of the result
//   in_ciphertext     ciphertext of the result
//   match_mask        bits to compare (0 = every result matches)
//   match_value       target ciphertext bits
//   rd_en             host pop request
//   out_valid         FIFO non-empty; head entry presented
//   out_counter       head counter
//   out_ciphertext    head ciphertext
//   out_timestamp     head timestamp (only with DES_COLLECT_TIMESTAMP_EN)
//   fifo_count        occupancy, 0..DEPTH
//   producer_hold     FIFO full
//   overflow          sticky: a match was dropped
//   drop_count        dropped matches, saturating
//   checked_count     results seen in RUN, wrapping
//   busy              state is RUN or FLUSH
module des_result_collector #(
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 48,
  parameter int STAT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     in_valid,
  input  logic [CNT_W-1:0]         in_counter,
  input  logic [63:0]              in_ciphertext,
  input  logic [63:0]              match_mask,
  input  logic [63:0]              match_value,
  input  logic                     rd_en,
  output logic                     out_valid,
  output logic [CNT_W-1:0]         out_counter,
  output logic [63:0]              out_ciphertext,
`ifdef DES_COLLECT_TIMESTAMP_EN
  output logic [31:0]              out_timestamp,
`endif
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     producer_hold,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  output logic [STAT_W-1:0]        checked_count,
  output logic                     busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = CNT_W + 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [EW-1:0]      r_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_overflow;
  logic [15:0]        r_drop;
  logic [STAT_W-1:0]  r_checked;

  logic               w_start_run;
  logic               w_match;
  logic               w_push_req;
  logic               w_pop;
  logic               w_full;
  logic               w_push;
  logic               w_drop;
  logic [EW-1:0]      w_head;

  assign w_start_run = (r_state == S_IDLE) && start;
  assign w_match     = ((in_ciphertext ^ match_value) & match_mask) == 64'd0;
  assign w_push_req  = (r_state == S_RUN) && in_valid && w_match;
  assign w_pop       = rd_en && (r_count != '0);
  assign w_full      = (r_count == CW'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_drop      = w_push_req && w_full && !w_pop;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic. start is only looked at in IDLE and stop only in
  // RUN. This makes start win when both arrive in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (stop) w_next = S_FLUSH;
      S_FLUSH: if (r_count == '0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FIFO control and statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop     <= '0;
      r_checked  <= '0;
    end else if (w_start_run) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop     <= '0;
      r_checked  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      end
      if ((r_state == S_RUN) && in_valid) r_checked <= r_checked + STAT_W'(1);
    end
  end

  // Entry storage. It is not reset: contents are qualified by r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_counter, in_ciphertext};
  end

  assign w_head         = r_mem[r_rd_ptr];
  assign out_valid      = (r_count != '0);
  assign out_counter    = out_valid ? w_head[EW-1:64] : '0;
  assign out_ciphertext = out_valid ? w_head[63:0]    : 64'd0;
  assign fifo_count     = r_count;
  assign producer_hold  = w_full;
  assign overflow       = r_overflow;
  assign drop_count     = r_drop;
  assign checked_count  = r_checked;
  assign busy           = (r_state != S_IDLE);

`ifdef DES_COLLECT_TIMESTAMP_EN
  logic [31:0] r_ts;
  logic [31:0] r_ts_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_ts <= '0;
    else if (w_start_run) r_ts <= '0;
    else                  r_ts <= r_ts + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_ts_mem[r_wr_ptr] <= r_ts;
  end

  assign out_timestamp = out_valid ? r_ts_mem[r_rd_ptr] : 32'd0;
`endif

endmodule

// File: tb/tb_des_result_collector.sv
module tb_des_result_collector;

  localparam int DEPTH  = 8;
  localparam int CNT_W  = 48;
  localparam int STAT_W = 32;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start, stop, in_valid, rd_en;
  logic [CNT_W-1:0]        in_counter;
  logic [63:0]             in_ciphertext, match_mask, match_value;
  logic                    out_valid;
  logic [CNT_W-1:0]        out_counter;
  logic [63:0]             out_ciphertext;
`ifdef DES_COLLECT_TIMESTAMP_EN
  logic [31:0]             out_timestamp;
`endif
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    producer_hold, overflow, busy;
  logic [15:0]             drop_count;
  logic [STAT_W-1:0]       checked_count;

  int n_checks = 0;
  int n_errors = 0;

  des_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .in_valid(in_valid), .in_counter(in_counter), .in_ciphertext(in_ciphertext),
    .match_mask(match_mask), .match_value(match_value), .rd_en(rd_en),
    .out_valid(out_valid), .out_counter(out_counter), .out_ciphertext(out_ciphertext),
`ifdef DES_COLLECT_TIMESTAMP_EN
    .out_timestamp(out_timestamp),
`endif
    .fifo_count(fifo_count), .producer_hold(producer_hold), .overflow(overflow),
    .drop_count(drop_count), .checked_count(checked_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [CNT_W-1:0] c, input logic [63:0] ct);
    in_valid = 1'b1; in_counter = c; in_ciphertext = ct;
    tick();
    in_valid = 1'b0;
  endtask

  // From RUN with an empty FIFO: stop, drain through FLUSH, start again.
  task automatic restart();
    stop = 1'b1; tick(); stop = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
    in_counter = '0; in_ciphertext = '0; match_mask = '0; match_value = '0;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hold", 64'(producer_hold), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_checked", 64'(checked_count), 64'd0);
    chk("rst_out_counter", 64'(out_counter), 64'd0);
    rst = 1'b0;
    tick();

    // Basic ordering with mask 0
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    in_valid = 1'b1; in_counter = 48'd5; in_ciphertext = 64'hC0DE_0000_0000_0005;
    chk("pre_push_valid", 64'(out_valid), 64'd0);
    tick();
    chk("fwft_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    push(48'd6, 64'hC0DE_0000_0000_0006);
    push(48'd7, 64'hC0DE_0000_0000_0007);
    chk("basic_checked", 64'(checked_count), 64'd3);
    chk("basic_count", 64'(fifo_count), 64'd3);
    chk("pop0_counter", 64'(out_counter), 64'd5);
    chk("pop0_ct", out_ciphertext, 64'hC0DE_0000_0000_0005);
    rd_en = 1'b1;
    tick(); chk("pop1_counter", 64'(out_counter), 64'd6);
    tick(); chk("pop2_counter", 64'(out_counter), 64'd7);
    tick(); rd_en = 1'b0;
    chk("basic_empty_count", 64'(fifo_count), 64'd0);
    chk("basic_empty_valid", 64'(out_valid), 64'd0);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("empty_pop_noop", 64'(fifo_count), 64'd0);

    // Masked compare
    restart();
    chk("restart_checked", 64'(checked_count), 64'd0);
    match_mask = 64'hFFFF_0000_0000_0000; match_value = 64'hABCD_0000_0000_0000;
    push(48'd1, 64'hABCD_0000_0000_0001);
    push(48'd2, 64'h1234_0000_0000_0001);
    chk("mask_checked", 64'(checked_count), 64'd2);
    chk("mask_count", 64'(fifo_count), 64'd1);
    chk("mask_head_ct", out_ciphertext, 64'hABCD_0000_0000_0001);
    chk("mask_head_cnt", 64'(out_counter), 64'd1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    match_mask = '0; match_value = '0;

    // Overflow
    restart();
    for (int i = 0; i < 10; i++) begin
      push(48'(i), 64'h5000_0000_0000_0000 | 64'(i));
      if (i == 7) begin
        chk("hold_after_8", 64'(producer_hold), 64'd1);
        chk("no_ovf_at_8", 64'(overflow), 64'd0);
      end
    end
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drops", 64'(drop_count), 64'd2);
    chk("ovf_count", 64'(fifo_count), 64'd8);
    chk("ovf_checked", 64'(checked_count), 64'd10);
    chk("ovf_head", 64'(out_counter), 64'd0);

    // Full with simultaneous push and pop
    rd_en = 1'b1; in_valid = 1'b1; in_counter = 48'd100; in_ciphertext = 64'h100;
    tick();
    in_valid = 1'b0;
    chk("fullpp_count", 64'(fifo_count), 64'd8);
    chk("fullpp_drops", 64'(drop_count), 64'd2);
    for (int i = 1; i <= 8; i++) begin
      chk("fullpp_order", 64'(out_counter), (i == 8) ? 64'd100 : 64'(i));
      tick();
    end
    rd_en = 1'b0;
    chk("fullpp_empty", 64'(fifo_count), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // FLUSH behaviour
    restart();
    chk("start_clears_ovf", 64'(overflow), 64'd0);
    chk("start_clears_drop", 64'(drop_count), 64'd0);
    push(48'd20, 64'h20); push(48'd21, 64'h21); push(48'd22, 64'h22);
    stop = 1'b1; tick(); stop = 1'b0;
    push(48'd99, 64'h99);
    chk("flush_ignored_count", 64'(fifo_count), 64'd3);
    chk("flush_ignored_checked", 64'(checked_count), 64'd3);
    chk("flush_busy", 64'(busy), 64'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("flush_start_ignored", 64'(fifo_count), 64'd3);
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("flush_pop", 64'(out_counter), 64'(20 + i));
      tick();
    end
    rd_en = 1'b0;
    chk("flush_busy_at_empty", 64'(busy), 64'd1);
    tick();
    chk("idle_busy", 64'(busy), 64'd0);
    push(48'd55, 64'h55);
    chk("idle_ignored_checked", 64'(checked_count), 64'd3);
    chk("idle_ignored_count", 64'(fifo_count), 64'd0);

    // Reset mid-RUN
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) push(48'(30 + i), 64'h30 + 64'(i));
    chk("prerst_count", 64'(fifo_count), 64'd4);
    rst = 1'b1; #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_count", 64'(fifo_count), 64'd0);
    chk("midrst_ovf", 64'(overflow), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    push(48'd42, 64'h42);
    chk("resume_valid", 64'(out_valid), 64'd1);
    chk("resume_counter", 64'(out_counter), 64'd42);
    chk("resume_checked", 64'(checked_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
